firram_ring: RTL
================

Name: firram_ring

Overview:
- Parametrised multi-channel circular sample store for the polyphase FIR datapath.
- The write side appends samples per channel into a block-RAM ring.
- The read side is started by a request and bursts out the most recent `rd_len` samples of one channel, newest first, one per clock, to feed the MAC.
- Unwritten history reads as zero, so filter start-up after reset is clean.

Parameters:
- WIDTH, 36, sample word width in bits.
- DEPTH, 128, ring depth per channel in words; power of 2, minimum 4.
- NCH, 2, number of channels; minimum 1.
- AW, log2(DEPTH), derived, per-channel pointer width.
- CW, max(1, ceil(log2(NCH))), derived, channel index width.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe; one sample per cycle.
- wr_ch  in  CW  channel of the write.
- wr_data  in  WIDTH  sample to store.
- rd_start  in  1  burst request; sampled only while idle.
- rd_ch  in  CW  channel to read; latched on accept.
- rd_len  in  AW+1  burst length, 1..DEPTH; latched on accept.
- rd_busy  out  1  burst in progress.
- rd_data  out  WIDTH  registered output sample.
- rd_valid  out  1  rd_data is valid this cycle.
- rd_last  out  1  final word of the burst; coincident with rd_valid.

Behaviour:
- Storage: NCH*DEPTH words in one simple-dual-port block RAM at address {ch, ptr}. Read port is registered (1 cycle) and read-first on same-address collision.
- Per-channel state:
  - wp[ch] (AW bits): reset 0; points to the next slot to write.
  - fill[ch] (AW+1 bits): reset 0; saturates at DEPTH.
- Write:
  - wr_en with wr_ch < NCH stores wr_data at {wr_ch, wp}, then wp <= wp+1 mod DEPTH and fill <= min(fill+1, DEPTH).
  - wr_ch >= NCH is ignored; no state changes.
- Read FSM states: IDLE, RUN, FLUSH.
  - IDLE: rd_start with rd_len in 1..DEPTH and rd_ch < NCH is accepted in cycle T. Latch ch, len, base = wp[ch], valid window = fill[ch]. Go to RUN. Any other rd_start is ignored.
  - RUN: issue read address k = 0..len-1 at cycles T+1..T+len, ptr = base-1-k mod DEPTH. After issuing k = len-1, go to FLUSH.
  - FLUSH: one cycle while the last word drains; then IDLE.
  - A new rd_start may be accepted in the cycle the FSM returns to IDLE, i.e. the cycle after rd_last.
- Output pipeline:
  - The word for index k appears on rd_data with rd_valid=1 at cycle T+2+k. Latency from accept to first word is 2 cycles; throughput is 1 word/cycle with no gaps.
  - rd_data is forced to 0 for any k >= latched fill (zero-masked history).
  - rd_last=1 with the word k = len-1.
  - rd_busy=1 from T+1 through the rd_last cycle inclusive.
  - rd_valid=0 outside a burst; rd_data holds its last value when not valid.
- Writes during a burst:
  - Writes to any channel continue during a burst.
  - base and window are snapshotted at accept, so a burst returns exactly the snapshot window provided the number of writes to the active channel during the burst is <= DEPTH-len.
  - Beyond that limit, returned data is unspecified; the scheduler guarantees the limit.
- Wrap-around: pointer arithmetic is modulo DEPTH per channel and never crosses into another channel's region.
- Reset values: rd_busy=0, rd_valid=0, rd_last=0, rd_data=0, FSM=IDLE, all wp=0, all fill=0.
- Reset mid-burst: the burst is aborted with no further rd_valid. RAM contents are not cleared but become invisible through fill=0.
- rd_len=DEPTH with fill=DEPTH returns the entire ring, oldest word last.

Test Plan:
- Zero-fill start-up: after rst, write 3 samples 1,2,3 to ch0; rd_start ch0 len 5 -> rd_data 3,2,1,0,0 at T+2..T+6; rd_last at T+6; rd_busy T+1..T+6.
- Wrap: write 130 samples 0..129 to ch0 with DEPTH=128; read len 128 -> 129,128,...,2; rd_last with value 2.
- Channel isolation: interleave ch0 writes 100..109 with ch1 writes 200..209; read ch1 len 4 -> 209,208,207,206; then ch0 len 2 -> 109,108.
- Write during burst: read ch0 len 8 while writing 5 new ch0 samples mid-burst -> the 8 pre-accept snapshot values, unaffected.
- Illegal and overlapping requests: rd_len=0, rd_ch=NCH, and rd_start while busy -> no burst, no rd_valid; rd_start in the cycle after rd_last -> accepted, first word 2 cycles later.
- Reset mid-burst: assert rst at burst word 3 of len 10 -> rd_valid/rd_busy low the next cycle; subsequent read ch0 len 4 -> 0,0,0,0.

Source files
------------

// File: rtl/firram_ring.sv
// firram_ring: multi-channel circular sample store for the polyphase FIR datapath.
//
// Each channel owns a DEPTH-word region of a single simple-dual-port RAM
// addressed as {ch, ptr}. The write side appends samples to a channel's ring.
// The read side accepts a burst request and streams the newest rd_len samples
// of one channel, newest first, one word per clock.
//
// Only the first `fill` words of a channel have ever been written since
// reset. Any history older than that reads back as zero, so the MAC sees
// clean zero history after reset.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   wr_en     write strobe, one sample per cycle
//   wr_ch     channel of the write (ignored when >= NCH)
//   wr_data   sample to store
//   rd_start  burst request, sampled only while idle
//   rd_ch     channel to read, latched on accept
//   rd_len    burst length 1..DEPTH, latched on accept
//   rd_busy   burst in progress (first issue cycle through rd_last)
//   rd_data   registered output sample, holds when not valid
//   rd_valid  rd_data valid this cycle
//   rd_last   final word of the burst
module firram_ring #(
  parameter int  WIDTH = 36,
  parameter int  DEPTH = 128,
  parameter int  NCH   = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [CW-1:0]    wr_ch,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_start,
  input  logic [CW-1:0]    rd_ch,
  input  logic [AW:0]      rd_len,
  output logic             rd_busy,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_last
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  // Fill count saturates at DEPTH: once the ring has wrapped, every slot is live.
  function automatic logic [AW:0] fill_sat_inc(input logic [AW:0] f);
    return (f == (AW+1)'(DEPTH)) ? f : f + (AW+1)'(1);
  endfunction

  function automatic logic ch_ok(input logic [CW-1:0] ch);
    return ({1'b0, ch} < (CW+1)'(NCH));
  endfunction

  logic [WIDTH-1:0] mem [NCH*DEPTH];

  logic [AW-1:0] wp   [NCH];
  logic [AW:0]   fill [NCH];

  state_t state, state_nx;

  logic          wr_ok;
  logic          accept;
  logic          len_ok;

  // Burst snapshot taken at accept; base and window stay fixed for the burst
  // even while writes continue to the same channel.
  logic [CW-1:0] ch_p0;
  logic [AW:0]   len_p0;
  logic [AW-1:0] base_p0;
  logic [AW:0]   win_p0;
  logic [AW-1:0] k_p0;

  logic          vld_p0;
  logic          last_p0;
  logic          zero_p0;
  logic [AW-1:0] ptr_p0;
  logic [CW+AW-1:0] raddr;
  logic [CW+AW-1:0] waddr;

  assign wr_ok  = wr_en && ch_ok(wr_ch);
  assign waddr  = {wr_ch, wp[wr_ch]};
  assign len_ok = (rd_len != '0) && (rd_len <= (AW+1)'(DEPTH));
  assign accept = (state == IDLE) && rd_start && len_ok && ch_ok(rd_ch);

  // Write side: per-channel pointer and fill count
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        wp[i]   <= '0;
        fill[i] <= '0;
      end
    end else if (wr_ok) begin
      wp[wr_ch]   <= wp[wr_ch] + AW'(1);
      fill[wr_ch] <= fill_sat_inc(fill[wr_ch]);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[waddr] <= wr_data;
  end

  // Read FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Read FSM: next state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept)  state_nx = RUN;
      RUN:     if (last_p0) state_nx = FLUSH;
      FLUSH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Read FSM: outputs
  always_comb begin
    rd_busy = (state != IDLE);
    vld_p0  = (state == RUN);
  end

  // Stage p0: snapshot on accept, then one read address per cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      ch_p0   <= rd_ch;
      len_p0  <= rd_len;
      base_p0 <= wp[rd_ch];
      win_p0  <= fill[rd_ch];
      k_p0    <= '0;
    end else if (vld_p0) begin
      k_p0    <= k_p0 + AW'(1);
    end
  end

  // base points at the next free slot, so the newest sample sits at base-1.
  assign ptr_p0  = base_p0 - k_p0 - AW'(1);
  assign raddr   = {ch_p0, ptr_p0};
  assign last_p0 = ({1'b0, k_p0} == (len_p0 - (AW+1)'(1)));
  assign zero_p0 = ({1'b0, k_p0} >= win_p0);

  // Stage p1: registered RAM read with zero-mask, plus output flags.
  // Reading the old word on a same-address write falls out of the NBA ordering.
  always_ff @(posedge clk) begin
    if (rst)         rd_data <= '0;
    else if (vld_p0) rd_data <= zero_p0 ? '0 : mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= vld_p0;
      rd_last  <= vld_p0 && last_p0;
    end
  end

endmodule
